// File: rtl/rst_seq_pkg.sv
// Shared types, default parameters and sizing helper for the reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2,
    SOFT    = 2'd3
  } state_e;

  localparam int unsigned N_STAGES_DEF  = 3;
  localparam int unsigned STAGE_DLY_DEF = 16;
  localparam int unsigned SOFT_HOLD_DEF = 8;

  // Counter must hold the larger of the two delays.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/rst_delay_cnt.sv
// Loadable down-counter; done_c flags the last cycle of a loaded delay.
module rst_delay_cnt #(
  parameter int unsigned W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done_c
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // Saturates at zero so an idle counter never re-fires done_c.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_c = (cnt_q == W'(1));

endmodule

// File: rtl/rst_sequencer.sv
// Board-reset synchronizer plus ordered release of downstream reset domains,
// with an acknowledged soft-reset replay.
module rst_sequencer
  import rst_seq_pkg::*;
#(
  parameter int unsigned N_STAGES  = N_STAGES_DEF,
  parameter int unsigned STAGE_DLY = STAGE_DLY_DEF,
  parameter int unsigned SOFT_HOLD = SOFT_HOLD_DEF
) (
  input  logic                i_clk,
  input  logic                i_nrst,
  input  logic                i_soft_req,
  output logic                o_soft_ack,
  output logic [N_STAGES-1:0] o_nrst_stage,
  output logic                o_ready
);

  localparam int unsigned CNT_W = cnt_width(STAGE_DLY, SOFT_HOLD);
  localparam int unsigned IDX_W = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;

  logic [1:0]          sync_q, sync_d;
  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [N_STAGES-1:0] stage_q, stage_d;
  logic                ready_q, ready_d;
  logic                ack_q, ack_d;
  logic                armed_q, armed_d;

  logic                sync_nrst;
  logic                cnt_load;
  logic [CNT_W-1:0]    cnt_val;
  logic                cnt_done_c;

  assign sync_nrst = sync_q[1];

  rst_delay_cnt #(.W(CNT_W)) u_dly (
    .clk      (i_clk),
    .rst_n    (i_nrst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .done_c   (cnt_done_c)
  );

  always_comb begin
    sync_d   = {sync_q[0], 1'b1};
    state_d  = state_q;
    idx_d    = idx_q;
    stage_d  = stage_q;
    ready_d  = ready_q;
    ack_d    = 1'b0;
    // A low sample re-arms; a level held across an ack stays disarmed.
    armed_d  = armed_q | ~i_soft_req;
    cnt_load = 1'b0;
    cnt_val  = CNT_W'(STAGE_DLY);

    unique case (state_q)
      HOLD: begin
        if (sync_nrst) begin
          cnt_load = 1'b1;
          idx_d    = '0;
          state_d  = RELEASE;
        end
      end
      RELEASE: begin
        if (cnt_done_c) begin
          for (int unsigned k = 0; k < N_STAGES; k++) begin
            if (idx_q == IDX_W'(k)) stage_d[k] = 1'b1;
          end
          if (idx_q == IDX_W'(N_STAGES - 1)) begin
            ready_d = 1'b1;
            state_d = RUN;
          end else begin
            idx_d    = idx_q + IDX_W'(1);
            cnt_load = 1'b1;
          end
        end
      end
      RUN: begin
        if (armed_q && i_soft_req) begin
          ack_d    = 1'b1;
          armed_d  = 1'b0;
          stage_d  = '0;
          ready_d  = 1'b0;
          cnt_load = 1'b1;
          cnt_val  = CNT_W'(SOFT_HOLD);
          state_d  = SOFT;
        end
      end
      SOFT: begin
        if (cnt_done_c) begin
          cnt_load = 1'b1;
          idx_d    = '0;
          state_d  = RELEASE;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sync_q  <= '0;
      state_q <= HOLD;
      idx_q   <= '0;
      stage_q <= '0;
      ready_q <= 1'b0;
      ack_q   <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      idx_q   <= idx_d;
      stage_q <= stage_d;
      ready_q <= ready_d;
      ack_q   <= ack_d;
      armed_q <= armed_d;
    end
  end

  assign o_nrst_stage = stage_q;
  assign o_ready      = ready_q;
  assign o_soft_ack   = ack_q;

endmodule

// File: tb/tb_rst_sequencer.sv
// Scoreboard bench: stimulus queues expected output changes, monitors pop on change.
module tb_rst_sequencer;

  typedef struct {
    int         e;
    logic [7:0] stage;
    logic       ready;
    logic       ack;
  } exp_t;

  logic       clk = 1'b0;
  logic       nrst, req, nrst2, req2;
  logic [2:0] stage;
  logic       ready, ack;
  logic [0:0] stage2;
  logic       ready2, ack2;

  int   total = 0;
  int   bad   = 0;
  int   edge_n, edge2;
  bit   mon_en = 1'b0;
  exp_t q1[$];
  exp_t q2[$];
  logic [9:0] prev1 = '0;
  logic [9:0] prev2 = '0;

  always #5 clk = ~clk;

  rst_sequencer u_dut (
    .i_clk        (clk),
    .i_nrst       (nrst),
    .i_soft_req   (req),
    .o_soft_ack   (ack),
    .o_nrst_stage (stage),
    .o_ready      (ready)
  );

  rst_sequencer #(.N_STAGES(1), .STAGE_DLY(1), .SOFT_HOLD(1)) u_dut_min (
    .i_clk        (clk),
    .i_nrst       (nrst2),
    .i_soft_req   (req2),
    .o_soft_ack   (ack2),
    .o_nrst_stage (stage2),
    .o_ready      (ready2)
  );

  // Edge numbering: first posedge after reset release is edge 0.
  always @(posedge clk or negedge nrst)
    if (!nrst) edge_n <= -1; else edge_n <= edge_n + 1;
  always @(posedge clk or negedge nrst2)
    if (!nrst2) edge2 <= -1; else edge2 <= edge2 + 1;

  task automatic push(input bit which, input int e, input logic [7:0] st,
                      input logic rd, input logic ak);
    exp_t x;
    x.e = e; x.stage = st; x.ready = rd; x.ack = ak;
    if (which) q2.push_back(x); else q1.push_back(x);
  endtask

  task automatic check_evt(input bit which, input int e, input logic [7:0] st,
                           input logic rd, input logic ak);
    exp_t x;
    int   sz;
    total++;
    sz = which ? q2.size() : q1.size();
    if (sz == 0) begin
      bad++;
      $display("FAIL unexpected_change dut%0d edge=%0d got stage=%b ready=%b ack=%b, required no change",
               which, e, st, rd, ak);
      return;
    end
    if (which) x = q2.pop_front(); else x = q1.pop_front();
    if (x.e !== e || x.stage !== st || x.ready !== rd || x.ack !== ak) begin
      bad++;
      $display("FAIL event dut%0d got edge=%0d stage=%b ready=%b ack=%b, required edge=%0d stage=%b ready=%b ack=%b",
               which, e, st, rd, ak, x.e, x.stage, x.ready, x.ack);
    end
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b required=%b", name, got, want);
    end
  endtask

  always begin
    @(negedge clk or negedge nrst);
    #1;
    if (mon_en && {8'(stage), ready, ack} !== prev1) begin
      check_evt(1'b0, edge_n, 8'(stage), ready, ack);
      prev1 = {8'(stage), ready, ack};
    end
  end

  always begin
    @(negedge clk or negedge nrst2);
    #1;
    if (mon_en && {8'(stage2), ready2, ack2} !== prev2) begin
      check_evt(1'b1, edge2, 8'(stage2), ready2, ack2);
      prev2 = {8'(stage2), ready2, ack2};
    end
  end

  task automatic wait_e(input bit which, input int n);
    int guard;
    guard = 0;
    @(negedge clk);
    while ((which ? edge2 : edge_n) != n) begin
      @(negedge clk);
      guard++;
      if (guard > 3000) begin
        $display("FAIL timeout dut%0d waiting for edge %0d", which, n);
        bad++;
        total++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic push_power_on();
    push(1'b0, 18, 8'b001, 1'b0, 1'b0);
    push(1'b0, 34, 8'b011, 1'b0, 1'b0);
    push(1'b0, 50, 8'b111, 1'b1, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    nrst = 1'b1; nrst2 = 1'b1; req = 1'b0; req2 = 1'b0;
    #3;
    nrst = 1'b0; nrst2 = 1'b0;
    #20;
    chk("reset_stage",  8'(stage),  8'h00);
    chk("reset_ready",  8'(ready),  8'h00);
    chk("reset_ack",    8'(ack),    8'h00);
    chk("reset_stage2", 8'(stage2), 8'h00);
    chk("reset_ready2", 8'(ready2), 8'h00);
    chk("reset_ack2",   8'(ack2),   8'h00);
    mon_en = 1'b1;

    // Power-on release at defaults
    @(negedge clk); nrst = 1'b1;
    push_power_on();

    // Soft reset at edge 60, request held 20 cycles
    wait_e(1'b0, 59); req = 1'b1;
    push(1'b0, 60,  8'b000, 1'b0, 1'b1);
    push(1'b0, 61,  8'b000, 1'b0, 1'b0);
    push(1'b0, 84,  8'b001, 1'b0, 1'b0);
    push(1'b0, 100, 8'b011, 1'b0, 1'b0);
    push(1'b0, 116, 8'b111, 1'b1, 1'b0);
    wait_e(1'b0, 79); req = 1'b0;

    // Request held well past the re-release into RUN: only one ack
    wait_e(1'b0, 129); req = 1'b1;
    push(1'b0, 130, 8'b000, 1'b0, 1'b1);
    push(1'b0, 131, 8'b000, 1'b0, 1'b0);
    push(1'b0, 154, 8'b001, 1'b0, 1'b0);
    push(1'b0, 170, 8'b011, 1'b0, 1'b0);
    push(1'b0, 186, 8'b111, 1'b1, 1'b0);
    wait_e(1'b0, 229); req = 1'b0;
    wait_e(1'b0, 240);

    // Request raised during sequencing waits for RUN
    push(1'b0, -1, 8'b000, 1'b0, 1'b0);
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    push_power_on();
    wait_e(1'b0, 19); req = 1'b1;
    push(1'b0, 51,  8'b000, 1'b0, 1'b1);
    push(1'b0, 52,  8'b000, 1'b0, 1'b0);
    push(1'b0, 75,  8'b001, 1'b0, 1'b0);
    push(1'b0, 91,  8'b011, 1'b0, 1'b0);
    push(1'b0, 107, 8'b111, 1'b1, 1'b0);
    wait_e(1'b0, 55); req = 1'b0;
    wait_e(1'b0, 115);

    // Async reset between stage 1 and stage 2 releases
    push(1'b0, -1, 8'b000, 1'b0, 1'b0);
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    push(1'b0, 18, 8'b001, 1'b0, 1'b0);
    push(1'b0, 34, 8'b011, 1'b0, 1'b0);
    wait_e(1'b0, 40);
    @(posedge clk); #2;
    push(1'b0, -1, 8'b000, 1'b0, 1'b0);
    nrst = 1'b0;
    #1;
    chk("async_stage", 8'(stage), 8'h00);
    chk("async_ready", 8'(ready), 8'h00);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    push_power_on();
    wait_e(1'b0, 60);

    // Minimum-parameter instance
    nrst2 = 1'b1;
    push(1'b1, 3, 8'b1, 1'b1, 1'b0);
    wait_e(1'b1, 9); req2 = 1'b1;
    push(1'b1, 10, 8'b0, 1'b0, 1'b1);
    push(1'b1, 11, 8'b0, 1'b0, 1'b0);
    push(1'b1, 12, 8'b1, 1'b1, 1'b0);
    wait_e(1'b1, 29); req2 = 1'b0;
    wait_e(1'b1, 40);

    chk("leftover_main", 8'(q1.size()), 8'h00);
    chk("leftover_min",  8'(q2.size()), 8'h00);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
